// File: rtl/board_pkg.sv
// Shared types and defaults for the board run-control block (board_ctrl).
package board_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HALT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_STEP  = 2'd3
  } ctrl_state_t;

  localparam int BOARD_DEBOUNCE_DEFAULT = 1000000;
  localparam int BOARD_RST_HOLD_DEFAULT = 16;

  function automatic logic core_enabled(input ctrl_state_t s);
    case (s)
      ST_RUN, ST_STEP: core_enabled = 1'b1;
      default:         core_enabled = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button conditioning: two-flop synchroniser, stable-count debouncer,
// and a registered one-cycle pulse on each accepted rising level.
module btn_debounce
  import board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BOARD_DEBOUNCE_DEFAULT
) (
  input  logic clk0,
  input  logic rst0,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  // The counter only runs while the synchronised input disagrees with the accepted level
  always_ff @(posedge clk0) begin
    if (rst0) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_level <= r_sync2;
        r_rise  <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule

// File: rtl/board_ctrl.sv
// Board run-control: debounced buttons drive a stretched core reset and a
// RUN/HALT/STEP core enable. Define BOARD_CTRL_STEP_EN to build the step path.
module board_ctrl
  import board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BOARD_DEBOUNCE_DEFAULT,
  parameter int RST_HOLD        = BOARD_RST_HOLD_DEFAULT,
  parameter int RUN_AT_RESET    = 1
) (
  input  logic       clk0,
  input  logic       rst0,
  input  logic       btn_rst,
  input  logic       btn_run,
  input  logic       btn_step,
  output logic       core_rst,
  output logic       core_en,
  output logic [1:0] state
);

  localparam int HW = $clog2(RST_HOLD + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD);

  logic          w_rst_level;
  logic          w_rst_rise;
  logic          w_run_level;
  logic          w_run_rise;
  logic          w_step_rise;
  logic          w_rst_src;
  logic          w_unused_bits;
  logic [HW-1:0] r_hold;
  ctrl_state_t   r_state;
  ctrl_state_t   w_next_state;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
    .clk0(clk0), .rst0(rst0), .raw(btn_rst), .level(w_rst_level), .rise(w_rst_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk0(clk0), .rst0(rst0), .raw(btn_run), .level(w_run_level), .rise(w_run_rise)
  );

`ifdef BOARD_CTRL_STEP_EN
  logic w_step_level;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk0(clk0), .rst0(rst0), .raw(btn_step), .level(w_step_level), .rise(w_step_rise)
  );

  assign w_unused_bits = ^{w_rst_rise, w_run_level, w_step_level};
`else
  assign w_step_rise   = 1'b0;
  assign w_unused_bits = ^{w_rst_rise, w_run_level, btn_step};
`endif

  assign w_rst_src = rst0 | w_rst_level;
  assign core_rst  = w_rst_src | (r_hold != '0);

  // Hold counter reloads while the reset source is active, then drains to zero
  always_ff @(posedge clk0) begin
    if (rst0) begin
      r_hold <= HOLD_INIT;
    end else if (w_rst_src) begin
      r_hold <= HOLD_INIT;
    end else if (r_hold != '0) begin
      r_hold <= r_hold - HW'(1);
    end else begin
      r_hold <= r_hold;
    end
  end

  // FSM state register
  always_ff @(posedge clk0) begin
    if (rst0) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: core reset dominates every button pulse; run beats step in HALT
  always_comb begin
    w_next_state = r_state;
    if (core_rst) begin
      w_next_state = ST_RESET;
    end else begin
      case (r_state)
        ST_RESET: w_next_state = (RUN_AT_RESET != 0) ? ST_RUN : ST_HALT;
        ST_HALT: begin
          if (w_run_rise) begin
            w_next_state = ST_RUN;
          end else if (w_step_rise) begin
            w_next_state = ST_STEP;
          end else begin
            w_next_state = ST_HALT;
          end
        end
        ST_RUN: begin
          if (w_run_rise) begin
            w_next_state = ST_HALT;
          end else begin
            w_next_state = ST_RUN;
          end
        end
        ST_STEP: w_next_state = ST_HALT;
        default: w_next_state = ST_RESET;
      endcase
    end
  end

  // Outputs decode straight from the state register
  always_comb begin
    core_en = core_enabled(r_state);
    state   = r_state;
  end

endmodule

// File: tb/tb_board_ctrl.sv
// Randomised + directed bench for board_ctrl against a history-window reference model.
module tb_board_ctrl;

  localparam int DB   = 4;
  localparam int HOLD = 3;

`ifdef BOARD_CTRL_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic       clk0 = 1'b0;
  logic       rst0;
  logic       btn_rst;
  logic       btn_run;
  logic       btn_step;
  logic       core_rst;
  logic       core_en;
  logic [1:0] state;

  board_ctrl #(.DEBOUNCE_CYCLES(DB), .RST_HOLD(HOLD), .RUN_AT_RESET(1)) dut (
    .clk0(clk0), .rst0(rst0), .btn_rst(btn_rst), .btn_run(btn_run),
    .btn_step(btn_step), .core_rst(core_rst), .core_en(core_en), .state(state)
  );

  always #5 clk0 = ~clk0;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference model: a button level flips once the last DB+1 synchronised
  // samples all disagree with it; core reset is held while the source has been
  // low for fewer than HOLD edges.
  bit m_s1[3];
  bit m_s2[3];
  bit m_hist[3][DB+1];
  bit m_lvl[3];
  bit m_rise[3];
  int m_low_run;
  int m_state;

  task automatic model_edge();
    bit raw[3];
    bit src;
    bit crst;
    bit all_diff;
    raw[0] = btn_rst; raw[1] = btn_run; raw[2] = btn_step;
    if (rst0) begin
      for (int b = 0; b < 3; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_rise[b] = 0;
        for (int k = 0; k <= DB; k++) m_hist[b][k] = 0;
      end
      m_low_run = 0;
      m_state = 0;
    end else begin
      src  = m_lvl[0];
      crst = src || (m_low_run < HOLD);
      if (crst) m_state = 0;
      else begin
        case (m_state)
          0: m_state = 2;
          1: begin
            if (m_rise[1]) m_state = 2;
            else if (m_rise[2] && STEP_EN) m_state = 3;
          end
          2: if (m_rise[1]) m_state = 1;
          default: m_state = 1;
        endcase
      end
      if (src) m_low_run = 0;
      else if (m_low_run < 1000000) m_low_run++;
      for (int b = 0; b < 3; b++) begin
        for (int k = DB; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
        m_hist[b][0] = m_s2[b];
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
        all_diff = 1;
        for (int k = 0; k <= DB; k++) if (m_hist[b][k] == m_lvl[b]) all_diff = 0;
        m_rise[b] = 0;
        if (all_diff) begin
          m_lvl[b]  = ~m_lvl[b];
          m_rise[b] = m_lvl[b];
          for (int k = 0; k <= DB; k++) m_hist[b][k] = m_lvl[b];
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    model_edge();
    @(negedge clk0);
    check_val("state", state, m_state);
    check_val("core_en", core_en, (m_state >= 2) ? 1 : 0);
    check_val("core_rst", core_rst, (rst0 || m_lvl[0] || (m_low_run < HOLD)) ? 1 : 0);
  endtask

  initial begin
    int n;
    int n_en;
    int saw_step;
    rst0 = 1'b1; btn_rst = 1'b0; btn_run = 1'b0; btn_step = 1'b0;

    // Power-up
    repeat (5) tick();
    check_val("por_core_rst", core_rst, 1);
    check_val("por_core_en", core_en, 0);
    check_val("por_state", state, 0);
    rst0 = 1'b0;
    n = 0;
    while (core_rst && n < 20) begin tick(); n++; end
    check_val("rst_stretch", n, HOLD);
    tick();
    check_val("por_run_state", state, 2);
    check_val("por_run_en", core_en, 1);

    // Bounce rejection then a clean hold
    for (int i = 0; i < 20; i++) begin
      btn_run = ((i / 2) % 2 == 0);
      tick();
      check_val("bounce_stay_run", state, 2);
    end
    btn_run = 1'b1;
    n = 0;
    while (state == 2'd2 && n < 30) begin tick(); n++; end
    check_val("run_latency", n, DB + 4);
    check_val("halt_state", state, 1);
    check_val("halt_en", core_en, 0);
    repeat (12) tick();
    check_val("held_run_single", state, 1);
    btn_run = 1'b0;
    repeat (DB + 6) tick();

    // Single step
    btn_step = 1'b1;
    n_en = 0;
    repeat (20) begin tick(); if (core_en) n_en++; end
    check_val("step_width", n_en, STEP_EN ? 1 : 0);
    check_val("step_back_halt", state, 1);
    btn_step = 1'b0;
    repeat (DB + 6) tick();

    // Simultaneous run and step
    btn_run = 1'b1; btn_step = 1'b1;
    saw_step = 0;
    repeat (12) begin tick(); if (state == 2'd3) saw_step++; end
    check_val("simul_no_step", saw_step, 0);
    check_val("simul_run", state, 2);
    btn_run = 1'b0; btn_step = 1'b0;
    repeat (DB + 6) tick();

    // Mid-run reset button
    btn_rst = 1'b1;
    n = 0;
    while (!core_rst && n < 30) begin tick(); n++; end
    check_val("btn_rst_latency", n, DB + 3);
    tick();
    check_val("btn_rst_state", state, 0);
    check_val("btn_rst_en", core_en, 0);
    repeat (5) tick();
    btn_rst = 1'b0;
    n = 0;
    while (core_rst && n < 40) begin tick(); n++; end
    check_val("btn_rst_release", n, DB + 3 + HOLD);
    tick();
    check_val("btn_rst_run", state, 2);

    // Randomised button activity
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) btn_run = ~btn_run;
      if ($urandom_range(0, 15) == 0) btn_step = ~btn_step;
      if ($urandom_range(0, 299) == 0) btn_rst = ~btn_rst;
      rst0 = ($urandom_range(0, 999) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_ctrl.md
# board_ctrl

Board-level run-control block that sits between the Nexys push-buttons and the `processor` instance, replacing the hard-tied `rst0 = 0` and `en0 = 1` drive. Three raw buttons (reset, run/pause, single-step) are synchronised and debounced, each at a parametrised depth. A small FSM then generates a stretched core reset and a core enable supporting free-run, halt and single-cycle step.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles before a button level is accepted (10 ms at 100 MHz); must be ≥1.
- `RST_HOLD`, default 16: cycles `core_rst` stays high after the reset source releases; must be ≥1.
- `RUN_AT_RESET`, default 1: 1 means leave reset into RUN, 0 means leave reset into HALT.
- `clk0`  input  1: the single clock (100 MHz board clock).
- `rst0`  input  1: reset, synchronous and active-high.
- `btn_rst`  input  1: raw reset button, asynchronous to `clk0`, active-high.
- `btn_run`  input  1: raw run/pause toggle button.
- `btn_step`  input  1: raw single-step button.
- `core_rst`  output  1: drives the processor `rst0`.
- `core_en`  output  1: drives the processor `en0`.
- `state`  output  2: current FSM state, for LED display.

## Operation
- **Per-button path**
  - Two-flop synchroniser, then a debounced level register, then a rising-edge pulse register.
  - When the synchronised value differs from the debounced level, a counter increments. The counter clears whenever the two agree.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level takes the synchronised value and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- **Reset source** is `rst0` OR the debounced `btn_rst` level. While the source is high, the hold counter loads `RST_HOLD`. While the source is low, the hold counter decrements to 0. `core_rst` = source OR (hold counter ≠ 0).
- **FSM states:** RESET, HALT, RUN, STEP.
  - Any state → RESET whenever `core_rst` = 1. This is checked first and overrides all button pulses, including mid-step and mid-run.
  - RESET → RUN when `RUN_AT_RESET` = 1, or RESET → HALT otherwise, on the first cycle with `core_rst` = 0.
  - RUN → HALT on a run pulse. Step pulses are ignored in RUN.
  - HALT → RUN on a run pulse. HALT → STEP on a step pulse. If run and step pulse in the same cycle, run wins.
  - STEP → HALT unconditionally after one cycle. Pulses arriving during STEP are dropped.
- **Outputs**
  - `core_en` = 1 in RUN and STEP, 0 in RESET and HALT. It is registered, so it reflects the state register.
  - `state` encoding: RESET = 0, HALT = 1, RUN = 2, STEP = 3.

## Timing
- **Reset values:** `core_rst` = 1, `core_en` = 0, `state` = RESET. All synchroniser, debounce, pulse and counter flops are 0. The hold counter is `RST_HOLD`.
- **Button latency:** a raw button edge held stable produces a one-cycle pulse exactly 2 + `DEBOUNCE_CYCLES` + 1 cycles later. The FSM state changes on the following edge.
- **Bounce rejection:** a glitch shorter than `DEBOUNCE_CYCLES` cycles at the synchroniser output produces no level change and no pulse.
- **Reset stretch:**
  - After `rst0` falls, `core_rst` falls exactly `RST_HOLD` cycles later.
  - The FSM leaves RESET on the next edge, so `core_en` first goes high `RST_HOLD` + 1 cycles after `rst0` falls (with `RUN_AT_RESET` = 1).
- **Step width:** a step yields exactly one cycle of `core_en` = 1.
- **Held buttons:** a held button generates one pulse only. It produces a new pulse only after a debounced release followed by a debounced press.

## Configuration
- `BOARD_CTRL_STEP_EN` defined: the step path and the STEP state are compiled in, as described above.
- `BOARD_CTRL_STEP_EN` undefined:
  - The `btn_step` port remains, but its synchroniser and debouncer are removed and the input is ignored.
  - STEP is unreachable. HALT leaves only via a run pulse or reset.

## Structure
- **`board_pkg`** holds:
  - the `ctrl_state_t` typedef (2-bit, encodings above);
  - default constants `BOARD_DEBOUNCE_DEFAULT` = 1000000 and `BOARD_RST_HOLD_DEFAULT` = 16.
- **`btn_debounce`** is the one natural sub-module.
  - Parameters: `DEBOUNCE_CYCLES`.
  - Ports: `clk0`, `rst0`, `raw`, `level`, `rise`.
  - It is instantiated once per button: three times with the macro defined, two without.
- `board` instantiates `board_ctrl` and wires `core_rst` / `core_en` to the processor's `rst0` / `en0`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `RST_HOLD` = 3.
- **Power-up:** `rst0` high for 5 cycles, then low → `core_rst` falls 3 cycles after `rst0` falls, `state` RESET → RUN (2) on the next edge, `core_en` = 1.
- **Bounce rejection:** `btn_run` toggled with 2-cycle pulses for 20 cycles, then held high → exactly one pulse, 7 cycles after the hold begins; RUN → HALT, `core_en` = 0.
- **Single step:** in HALT, press and hold `btn_step` → `state` 1 → 3 → 1, with `core_en` high for exactly one cycle. Holding the button produces no further steps.
- **Simultaneous press:** in HALT, `btn_run` and `btn_step` rise on the same cycle → `state` goes to RUN (2), with no STEP cycle.
- **Mid-run reset:** in RUN, press `btn_rst` → once the press is debounced, `core_rst` = 1 and `core_en` = 0 in the same edge's state. After release plus debounce, `core_rst` holds for 3 more cycles, then `state` = RUN.
- **Macro off** (build without `BOARD_CTRL_STEP_EN`): in HALT, press `btn_step` → `state` stays 1 and `core_en` stays 0.
